// File: rtl/input_conditioner_if.sv
// Bundles the per-channel conditioner signals between the pin side and the
// consumers; master drives the raw inputs, slave is the conditioner itself.
interface input_conditioner_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] repeat_en;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] press;
  logic                any_event;

  modport master (output raw_in, repeat_en,
                  input  level, rise, fall, press, any_event);
  modport slave  (input  raw_in, repeat_en,
                  output level, rise, fall, press, any_event);
endinterface

// File: rtl/input_conditioner.sv
// Per-channel synchronize / debounce / edge-detect / auto-repeat conditioner
// for asynchronous buttons and decoded key lines.
module input_conditioner_lane #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   REPEAT_DELAY    = 25000000,
  parameter int   REPEAT_RATE     = 5000000,
  parameter logic ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  input  logic rep_en_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic press_o
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RATE  = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic [1:0]             st_q, st_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d, press_q, press_d;
  logic norm, rep_pulse;

  // Polarity is fixed up after the chain so the chain idles at the pin level.
  assign norm = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (norm != level_q) begin
      if (dcnt_q == DEB_LAST) level_d = norm;
      else                    dcnt_d  = dcnt_q + DW'(1);
    end
  end

  assign rise_d = level_d & ~level_q;
  assign fall_d = ~level_d & level_q;

  always_comb begin
    st_d      = st_q;
    rcnt_d    = rcnt_q;
    rep_pulse = 1'b0;
    if (!level_d || !rep_en_i) begin
      st_d   = ST_IDLE;
      rcnt_d = '0;
    end else begin
      case (st_q)
        ST_IDLE: if (rise_d) begin
          st_d   = ST_DELAY;
          rcnt_d = '0;
        end
        ST_DELAY: if (rcnt_q == DLY_LAST) begin
          rep_pulse = 1'b1;
          st_d      = ST_RATE;
          rcnt_d    = '0;
        end else rcnt_d = rcnt_q + RW'(1);
        ST_RATE: if (rcnt_q == RATE_LAST) begin
          rep_pulse = 1'b1;
          rcnt_d    = '0;
        end else rcnt_d = rcnt_q + RW'(1);
        default: begin
          st_d   = ST_IDLE;
          rcnt_d = '0;
        end
      endcase
    end
  end

  assign press_d = rise_d | rep_pulse;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{ACTIVE_LOW}};
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      st_q    <= ST_IDLE;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      st_q    <= st_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign press_o = press_q;
endmodule

module input_conditioner #(
  parameter int                 CHANNELS        = 8,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 REPEAT_DELAY    = 25000000,
  parameter int                 REPEAT_RATE     = 5000000,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input_conditioner_if.slave   io
);
  logic [CHANNELS-1:0] level, rise, fall, press;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    input_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[g])
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (io.raw_in[g]),
      .rep_en_i(io.repeat_en[g]),
      .level_o (level[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g]),
      .press_o (press[g])
    );
  end

  assign io.level     = level;
  assign io.rise      = rise;
  assign io.fall      = fall;
  assign io.press     = press;
  // Built from registered pulses, so it is a clean single-cycle strobe.
  assign io.any_event = |(press | fall);
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised successor to the top-level button/keyboard-action synchronizer. It conditions CHANNELS asynchronous inputs (push buttons, switches, PS/2-decoded action lines) into the single clock domain. Each channel gets a per-channel polarity option, a metastability chain, a debouncer, registered edge pulses, and an optional hold-to-repeat press generator. It sits between the board pins / ps2_receiver and the processor, PC, and VGA logic.

Parameters:
CHANNELS, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, flip-flops in each synchronizer chain (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (>=1; 10 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles from the first press pulse to the first repeat pulse (>=1)
REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (>=1)
ACTIVE_LOW_MASK, {CHANNELS{1'b0}}, bit i = 1 means raw_in[i] is active-low (pin idles at 1)

Ports:
clock  input  1  system clock; all state is on the rising edge
reset  input  1  asynchronous, active-high reset
raw_in  input  CHANNELS  asynchronous raw inputs
repeat_en  input  CHANNELS  per-channel auto-repeat enable, synchronous to clock
level  output  CHANNELS  debounced, normalised (1 = active) level
rise  output  CHANNELS  one-cycle pulse when level goes 0->1
fall  output  CHANNELS  one-cycle pulse when level goes 1->0
press  output  CHANNELS  one-cycle pulse on rise, plus repeat pulses while held
any_event  output  1  OR of all press and fall bits in the same cycle

Behaviour:
- Reset (async assert, sync release handled by caller): sync flops load ACTIVE_LOW_MASK[i] (idle pin value). Debounce counters, repeat counters, level, rise, fall, press, and any_event all go to 0.
- norm[i] = sync_out[i] XOR ACTIVE_LOW_MASK[i]. Inversion is applied after the synchronizer, never before it.
- Debounce per channel:
  - If norm != level: cnt increments.
  - If norm != level and cnt == DEBOUNCE_CYCLES-1: level <= norm, cnt <= 0.
  - If norm == level: cnt <= 0. Any bounce restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency: level changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge after the raw change, counting the first edge that samples the new raw value. A raw pulse shorter than DEBOUNCE_CYCLES post-sync cycles produces no change.
- rise, fall, and press are registered. rise/fall are high exactly in the first cycle that level shows its new value, never longer than one cycle.
- Repeat state per channel: IDLE, DELAY, RATE.
  - Any state with level=0, or repeat_en[i]=0: go to IDLE, clear the counter.
  - IDLE: on the rise cycle, press=1. If repeat_en[i]=1, go to DELAY with the counter at 0.
  - DELAY: the counter counts cycles since the last press pulse. When it reaches REPEAT_DELAY, press=1 and go to RATE with the counter at 0.
  - RATE: on reaching REPEAT_RATE, press=1 and the counter restarts.
  - Deasserting repeat_en mid-hold suppresses further repeats. Reasserting it while still held does not restart repeats until the next rise.
- With repeat_en[i]=0, press == rise.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle, and any_event is a single 1-cycle high.
- Reset mid-operation (counting, holding, repeating) clears everything immediately. After release, a still-active input produces a fresh rise after full latency.
- Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).

Test Plan:
Bench parameters for all scenarios: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW_MASK=4'b0011.
1. Reset with raw_in=4'b0011 held idle: all outputs 0 during and after reset; no pulse in 50 cycles after release.
2. raw_in[2] 0->1 just before edge t: level[2]=1 after edge t+5. rise[2] and press[2] are high for exactly that one cycle. fall, and all other channels, stay 0.
3. Bounce on raw_in[0]: 1->0 held 3 cycles, then back to 1: no level/rise/press change. Then 0 held for 8 cycles: level[0]=1 with a single rise[0] pulse.
4. repeat_en[1]=1, ch1 held pressed for 30 cycles after level[1] rises (offset 0): press[1] pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28; rise[1] only at 0. On release: one fall[1] pulse and no further press.
5. raw_in[2] and raw_in[3] change in the same cycle: rise[2] and rise[3] pulse in the same cycle, and any_event is high for exactly 1 cycle.
6. Reset asserted at offset 12 of scenario 4: all outputs 0 immediately (asynchronous). After release with ch1 still pressed: rise[1]/press[1] after 6 edges, then repeat restarts from DELAY (next press 10 cycles later).
